note_key_scanner: RTL and testbench

Parametrised successor to the piano key encoder: samples `NOTES` note lines and `OCTAVES` octave-select lines and synchronises and debounces each one. It encodes the one valid (octave, note) pair into a note code and emits one-cycle `note_on`/`note_off` events for the tone generator downstream. It sits between the board IO pins and the synthesiser core, on the `clk_5MHz` domain.

---
 rtl/note_key_scanner.sv | 155 +++++++++++++++
 tb/tb_note_key_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/note_key_scanner.sv
// Key-line scanner: 2-flop sync, per-line debounce, (octave, note) encode, note_on/note_off FSM.
// Define NOTE_SUSTAIN_EN to keep the last released code on notecode while idle.
module note_key_scanner #(
    parameter int NOTES           = 7,
    parameter int OCTAVES         = 3,
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int CODE_W          = 5
) (
    input  logic                     clk_5MHz,
    input  logic                     rst,
    input  logic [NOTES+OCTAVES-1:0] IOs,
    output logic [CODE_W-1:0]        notecode,
    output logic                     note_valid,
    output logic                     note_on,
    output logic                     note_off
);

    localparam int L  = NOTES + OCTAVES;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, RELEASE, RETRIG} state_t;

    logic [L-1:0]      sync1_q, sync2_q, deb_q, deb_d;
    logic [CW-1:0]     cnt_q [L];
    logic [CW-1:0]     cnt_d [L];
    logic [CODE_W-1:0] enc_q, enc_d, cur_q, cur_d, pend_q, pend_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d, on_q, on_d, off_q, off_d;
    state_t            state_q, state_d;
    int                n_cnt, o_cnt, n_idx, o_idx;

    // The flip happens on the cycle the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < L; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        n_cnt = 0;
        o_cnt = 0;
        n_idx = 0;
        o_idx = 0;
        for (int n = 0; n < NOTES; n++) begin
            if (deb_q[n]) begin
                n_cnt = n_cnt + 1;
                n_idx = n;
            end
        end
        for (int k = 0; k < OCTAVES; k++) begin
            if (deb_q[NOTES+k]) begin
                o_cnt = o_cnt + 1;
                o_idx = k;
            end
        end
        enc_d = '0;
        if (n_cnt == 1 && o_cnt == 1) begin
            enc_d = CODE_W'(o_idx * NOTES + n_idx + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        on_d    = 1'b0;
        off_d   = 1'b0;
        valid_d = 1'b0;
`ifdef NOTE_SUSTAIN_EN
        code_d  = cur_q;
`else
        code_d  = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (enc_q != '0) begin
                    state_d = HELD;
                    cur_d   = enc_q;
                    on_d    = 1'b1;
                    valid_d = 1'b1;
                    code_d  = enc_q;
                end
            end
            HELD: begin
                code_d = cur_q;
                if (enc_q == '0) begin
                    state_d = RELEASE;
                    off_d   = 1'b1;
                end else if (enc_q != cur_q) begin
                    state_d = RETRIG;
                    pend_d  = enc_q;
                    off_d   = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            RETRIG: begin
                state_d = HELD;
                cur_d   = pend_q;
                on_d    = 1'b1;
                valid_d = 1'b1;
                code_d  = pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_5MHz or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < L; i++) cnt_q[i] <= '0;
            enc_q   <= '0;
            cur_q   <= '0;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync1_q <= IOs;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < L; i++) cnt_q[i] <= cnt_d[i];
            enc_q   <= enc_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            on_q    <= on_d;
            off_q   <= off_d;
            state_q <= state_d;
        end
    end

    assign notecode   = code_q;
    assign note_valid = valid_q;
    assign note_on    = on_q;
    assign note_off   = off_q;

endmodule

// File: tb/tb_note_key_scanner.sv
// Bench for note_key_scanner: directed scenarios plus random key traffic
// checked every cycle against a window-based behavioural model.
module tb_note_key_scanner;

    localparam int D  = 4;
    localparam int NN = 7;
    localparam int NO = 3;
    localparam int L  = NN + NO;
`ifdef NOTE_SUSTAIN_EN
    localparam bit SUST = 1'b1;
`else
    localparam bit SUST = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [L-1:0] IOs;
    logic [4:0]   notecode;
    logic         note_valid, note_on, note_off;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    note_key_scanner #(
        .NOTES(NN), .OCTAVES(NO), .DEBOUNCE_CYCLES(D), .CODE_W(5)
    ) dut (
        .clk_5MHz  (clk),
        .rst       (rst),
        .IOs       (IOs),
        .notecode  (notecode),
        .note_valid(note_valid),
        .note_on   (note_on),
        .note_off  (note_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: raw samples per edge, newest at index 0.
    logic [L-1:0] hist [0:D];
    logic [L-1:0] m_deb;
    logic [4:0]   m_enc, m_cur, m_pend;
    int           m_mode;
    bit           m_on;

    function automatic logic [4:0] enc_of(input logic [L-1:0] d);
        int nc = 0, oc = 0, ni = 0, oi = 0;
        for (int n = 0; n < NN; n++) if (d[n]) begin nc++; ni = n; end
        for (int k = 0; k < NO; k++) if (d[NN+k]) begin oc++; oi = k; end
        if (nc == 1 && oc == 1) return 5'(oi * NN + ni + 1);
        return 5'd0;
    endfunction

    // A line flips when the D raw samples that reached the debouncer all disagree.
    function automatic bit should_flip(input int i);
        for (int m = 1; m <= D; m++) if (hist[m][i] == m_deb[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        logic [L-1:0] nd;
        if (rst) begin
            for (int m = 0; m <= D; m++) hist[m] = '0;
            m_deb = '0; m_enc = '0; m_cur = '0; m_pend = '0;
            m_mode = 0; m_on = 1'b0;
        end else begin
            m_on = 1'b0;
            case (m_mode)
                0: if (m_enc != 0) begin m_mode = 1; m_cur = m_enc; m_on = 1'b1; end
                1: if (m_enc == 0) m_mode = 2;
                   else if (m_enc != m_cur) begin m_pend = m_enc; m_mode = 3; end
                2: m_mode = 0;
                default: begin m_mode = 1; m_cur = m_pend; m_on = 1'b1; end
            endcase
            m_enc = enc_of(m_deb);
            nd = m_deb;
            for (int i = 0; i < L; i++) if (should_flip(i)) nd[i] = ~m_deb[i];
            m_deb = nd;
            for (int m = D; m > 0; m--) hist[m] = hist[m-1];
            hist[0] = IOs;
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [4:0] c;
        c = (m_mode == 0) ? (SUST ? m_cur : 5'd0) : m_cur;
        return {c, m_mode == 1, m_on, m_mode == 2 || m_mode == 3};
    endfunction

    wire [7:0] dut_vec = {notecode, note_valid, note_on, note_off};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) check("cycle {code,valid,on,off}", dut_vec, exp_vec());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_pair();
        IOs = '0;
        IOs[NN + $urandom_range(0, NO-1)] = 1'b1;
        IOs[$urandom_range(0, NN-1)] = 1'b1;
    endtask

    initial begin
        int idx;
        rst = 1'b1;
        IOs = '0;
        tick(3);
        cmp_en = 1'b1;
        check("reset_state", dut_vec, 8'h00);
        rst = 1'b0;

        // 1: async reset with a note likely held
        rand_pair();
        tick(12);
        #2 rst = 1'b1;
        #1 check("rst_async", dut_vec, 8'h00);
        IOs = L'($urandom);
        tick(3);
        check("rst_hold", dut_vec, 8'h00);
        IOs = '0;
        rst = 1'b0;

        // 2: glitch on a note line is rejected
        IOs = 10'b10_0000_0000 >> 2;
        tick(8);
        IOs[0] = 1'b1;
        tick(3);
        IOs[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check("glitch_no_on", note_on, 1'b0);
        end
        check("glitch_code", notecode, 5'd0);

        // 3: press octave 1 note 2 -> code 10 at edge 7
        IOs = 10'b01_0000_0100;
        tick(7);
        check("press_edge6", dut_vec, 8'h00);
        tick(1);
        check("press_edge7", dut_vec, {5'd10, 3'b110});
        tick(1);
        check("press_steady", dut_vec, {5'd10, 3'b100});

        // 4: retrigger 10 -> 12
        IOs = 10'b01_0001_0000;
        tick(7);
        check("retrig_pre", dut_vec, {5'd10, 3'b100});
        tick(1);
        check("retrig_off", dut_vec, {5'd10, 3'b001});
        tick(1);
        check("retrig_on", dut_vec, {5'd12, 3'b110});

        // 5: back to 10, then add a second note -> release
        IOs = 10'b01_0000_0100;
        tick(12);
        check("back_to_10", dut_vec, {5'd10, 3'b100});
        IOs = 10'b01_0010_0100;
        tick(8);
        check("inv_rel_off", dut_vec, {5'd10, 3'b001});
        tick(1);
        check("inv_rel_idle", dut_vec, {SUST ? 5'd10 : 5'd0, 3'b000});

        // 6: reset while held, then a fresh press after release of reset
        IOs = 10'b01_0000_0100;
        tick(12);
        check("held_again", dut_vec, {5'd10, 3'b100});
        #2 rst = 1'b1;
        #1 check("rst_mid_note", dut_vec, 8'h00);
        tick(3);
        check("rst_no_off", note_off, 1'b0);
        rst = 1'b0;
        tick(7);
        check("post_rst_edge6", note_on, 1'b0);
        tick(1);
        check("post_rst_on", dut_vec, {5'd10, 3'b110});

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                rand_pair();
            end else if ($urandom_range(0, 24) == 0) begin
                idx = $urandom_range(0, L-1);
                IOs[idx] = ~IOs[idx];
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 check("rand_rst_async", dut_vec, 8'h00);
                tick(2);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
